// File: rtl/cot_fsm.sv
// cot_fsm: multi-cycle control unit for the accumulator CPU.
// Sequences fetch, operand read, execute and halt, and drives the datapath strobes.
module cot_fsm #(
    parameter int OPW     = 4,
    parameter int MEM_LAT = 1,
    parameter int CNTW    = 16
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iRun,
    input  logic [OPW-1:0]  iInst,
    input  logic            iZero,
    input  logic            iCarry,
    output logic            oMemRd,
    output logic            oIrLd,
    output logic            oPcInc,
    output logic            oPcLd,
    output logic            oAccwr,
    output logic            oDatawr,
    output logic [3:0]      oOP,
    output logic            oStop,
    output logic            oIllegal,
    output logic [CNTW-1:0] oRetired
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_OPRD   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    localparam logic [3:0] OP_CLA  = 4'b0000;
    localparam logic [3:0] OP_COM  = 4'b0001;
    localparam logic [3:0] OP_SHR  = 4'b0010;
    localparam logic [3:0] OP_CSL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_STA  = 4'b0101;
    localparam logic [3:0] OP_LDA  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JC   = 4'b1001;
    localparam logic [3:0] OP_STP  = 4'b1111;
    localparam logic [3:0] OP_NONE = 4'b1111;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [3:0]      r_wait;
    logic [3:0]      r_op;
    logic            r_run_q;
    logic            r_illegal;
    logic [CNTW-1:0] r_retired;
    logic            w_wait_done;
    logic            w_resume;
    logic            w_dec_illegal;

    // Opcodes 1010..1110 are reserved, as is anything with a bit set above bit 3.
    function automatic logic f_illegal(input logic [OPW-1:0] op);
        logic v;
        v = (op[3:0] >= 4'b1010) && (op[3:0] <= 4'b1110);
        for (int i = 4; i < OPW; i++) begin
            v = v | op[i];
        end
        return v;
    endfunction

    assign w_wait_done   = (r_wait == LAST_WAIT);
    assign w_resume      = iRun & ~r_run_q;
    assign w_dec_illegal = f_illegal(iInst);

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iRun) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_wait_done) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_dec_illegal) begin
                    w_next = S_HALT;
                end else if (iInst[3:0] == OP_STP) begin
                    w_next = S_HALT;
                end else if ((iInst[3:0] == OP_ADD) || (iInst[3:0] == OP_LDA)) begin
                    w_next = S_OPRD;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_OPRD: begin
                if (w_wait_done) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_OPRD;
                end
            end
            S_EXEC: begin
                if (iRun) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_HALT: begin
                if (w_resume) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_HALT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, wait counter, opcode, run-edge, illegal flag and retired counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_wait    <= 4'd0;
            r_op      <= OP_NONE;
            r_run_q   <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_run_q <= iRun;
            if (((r_state == S_FETCH) || (r_state == S_OPRD)) && !w_wait_done) begin
                r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= 4'd0;
            end
            if (r_state == S_DECODE) begin
                r_op <= iInst[3:0];
            end
            if ((r_state == S_DECODE) && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end else if ((r_state == S_HALT) && w_resume) begin
                r_illegal <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

    // Strobe decode; reset forces every output to its idle value in the same cycle.
    always_comb begin
        oMemRd   = 1'b0;
        oIrLd    = 1'b0;
        oPcInc   = 1'b0;
        oPcLd    = 1'b0;
        oAccwr   = 1'b0;
        oDatawr  = 1'b0;
        oOP      = OP_NONE;
        oStop    = 1'b0;
        oIllegal = 1'b0;
        oRetired = '0;
        if (iRst) begin
            oStop = 1'b1;
        end else begin
            oIllegal = r_illegal;
            oRetired = r_retired;
            case (r_state)
                S_IDLE: oStop = 1'b1;
                S_FETCH: begin
                    oMemRd = 1'b1;
                    oIrLd  = w_wait_done;
                    oPcInc = w_wait_done;
                end
                S_DECODE: oStop = 1'b0;
                S_OPRD:   oMemRd = 1'b1;
                S_EXEC: begin
                    oOP = r_op;
                    case (r_op)
                        OP_CLA, OP_COM, OP_SHR, OP_CSL, OP_ADD, OP_LDA: oAccwr = 1'b1;
                        OP_STA: oDatawr = 1'b1;
                        OP_JMP: oPcLd = 1'b1;
                        OP_JZ:  oPcLd = iZero;
                        OP_JC:  oPcLd = iCarry;
                        default: oPcLd = 1'b0;
                    endcase
                end
                S_HALT: oStop = 1'b1;
                default: oStop = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_cot_fsm.sv
// Self-checking bench for cot_fsm: three instances with different latency, opcode width
// and counter width, driven by directed and random instruction streams.
module tb_cot_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, run, zero, carry;
    logic [3:0] inst0, inst2;
    logic [5:0] inst1;
    logic [2:0] memrd, irld, pcinc, pcld, accwr, datawr, stop, illegal;
    logic [3:0] opv0, opv1, opv2;
    logic [15:0] ret0, ret1;
    logic [1:0] ret2;

    int checks = 0;
    int errors = 0;
    int mret [3];
    bit mill [3];
    bit halted;
    bit in_fetch;
    logic [5:0] rop;

    localparam logic [10:0] IDLE_PAT = {7'b0000001, 4'hF};

    cot_fsm #(.OPW(4), .MEM_LAT(1), .CNTW(16)) u0 (
        .iClk(clk), .iRst(rst[0]), .iRun(run[0]), .iInst(inst0), .iZero(zero[0]), .iCarry(carry[0]),
        .oMemRd(memrd[0]), .oIrLd(irld[0]), .oPcInc(pcinc[0]), .oPcLd(pcld[0]), .oAccwr(accwr[0]),
        .oDatawr(datawr[0]), .oOP(opv0), .oStop(stop[0]), .oIllegal(illegal[0]), .oRetired(ret0));
    cot_fsm #(.OPW(6), .MEM_LAT(2), .CNTW(16)) u1 (
        .iClk(clk), .iRst(rst[1]), .iRun(run[1]), .iInst(inst1), .iZero(zero[1]), .iCarry(carry[1]),
        .oMemRd(memrd[1]), .oIrLd(irld[1]), .oPcInc(pcinc[1]), .oPcLd(pcld[1]), .oAccwr(accwr[1]),
        .oDatawr(datawr[1]), .oOP(opv1), .oStop(stop[1]), .oIllegal(illegal[1]), .oRetired(ret1));
    cot_fsm #(.OPW(4), .MEM_LAT(3), .CNTW(2)) u2 (
        .iClk(clk), .iRst(rst[2]), .iRun(run[2]), .iInst(inst2), .iZero(zero[2]), .iCarry(carry[2]),
        .oMemRd(memrd[2]), .oIrLd(irld[2]), .oPcInc(pcinc[2]), .oPcLd(pcld[2]), .oAccwr(accwr[2]),
        .oDatawr(datawr[2]), .oOP(opv2), .oStop(stop[2]), .oIllegal(illegal[2]), .oRetired(ret2));

    function automatic int lat(input int k);
        return k + 1;
    endfunction

    function automatic int cmod(input int k);
        return (k == 2) ? 4 : 65536;
    endfunction

    function automatic logic [15:0] get_ret(input int k);
        case (k)
            0: return ret0;
            1: return ret1;
            default: return {14'd0, ret2};
        endcase
    endfunction

    function automatic logic [3:0] get_op(input int k);
        case (k)
            0: return opv0;
            1: return opv1;
            default: return opv2;
        endcase
    endfunction

    function automatic bit is_illegal(input int k, input logic [5:0] op);
        return ((k == 1) && (op[5:4] != 2'd0)) || ((op[3:0] >= 4'd10) && (op[3:0] <= 4'd14));
    endfunction

    function automatic logic [10:0] pk(input bit mr, input bit ir, input bit pi, input bit pl,
                                       input bit aw, input bit dw, input bit st, input logic [3:0] o);
        return {mr, ir, pi, pl, aw, dw, st, o};
    endfunction

    task automatic set_inst(input int k, input logic [5:0] op);
        case (k)
            0: inst0 = op[3:0];
            1: inst1 = op;
            default: inst2 = op[3:0];
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int k, input string tag, input logic [10:0] exp);
        chk($sformatf("u%0d/%s/strobes", k, tag),
            {21'd0, memrd[k], irld[k], pcinc[k], pcld[k], accwr[k], datawr[k], stop[k], get_op(k)},
            {21'd0, exp});
        chk($sformatf("u%0d/%s/illegal", k, tag), {31'd0, illegal[k]}, {31'd0, mill[k]});
        chk($sformatf("u%0d/%s/retired", k, tag), {16'd0, get_ret(k)}, 32'(mret[k]));
    endtask

    // From IDLE: raise iRun; the unit must still look idle this cycle.
    task automatic start(input int k);
        run[k] = 1'b1;
        #1 check_outs(k, "idle", IDLE_PAT);
        @(negedge clk);
    endtask

    // Entry: first FETCH cycle. Walks one instruction through the expected schedule.
    task automatic run_instr(input int k, input logic [5:0] op, input bit z, input bit c,
                             input bit keep, output bit hlt);
        logic [3:0] o;
        bit pl;
        o = op[3:0];
        hlt = 1'b0;
        set_inst(k, op);
        for (int i = 0; i < lat(k); i++) begin
            if (i == 0) run[k] = keep;
            #1 check_outs(k, "fetch", pk(1'b1, i == lat(k) - 1, i == lat(k) - 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
            @(negedge clk);
        end
        #1 check_outs(k, "decode", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
        @(negedge clk);
        if (is_illegal(k, op) || (o == 4'hF)) begin
            if (is_illegal(k, op)) mill[k] = 1'b1;
            #1 check_outs(k, "halt_entry", IDLE_PAT);
            @(negedge clk);
            hlt = 1'b1;
            return;
        end
        if ((o == 4'd4) || (o == 4'd6)) begin
            for (int i = 0; i < lat(k); i++) begin
                #1 check_outs(k, "oprd", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
                @(negedge clk);
            end
        end
        zero[k] = z;
        carry[k] = c;
        pl = (o == 4'd7) || ((o == 4'd8) && z) || ((o == 4'd9) && c);
        #1 check_outs(k, "exec", pk(1'b0, 1'b0, 1'b0, pl, (o <= 4'd6) && (o != 4'd5), o == 4'd5, 1'b0, o));
        @(negedge clk);
        mret[k] = (mret[k] + 1) % cmod(k);
    endtask

    // Entry: second HALT cycle. Hold iRun, then pulse it low/high to resume into FETCH.
    task automatic resume(input int k);
        for (int i = 0; i < 2; i++) begin
            #1 check_outs(k, "halt_hold", IDLE_PAT);
            @(negedge clk);
        end
        run[k] = 1'b0;
        #1 check_outs(k, "halt_low", IDLE_PAT);
        @(negedge clk);
        run[k] = 1'b1;
        #1 check_outs(k, "halt_rise", IDLE_PAT);
        @(negedge clk);
        mill[k] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 3'b111; run = 3'b000; zero = 3'b000; carry = 3'b000;
        inst0 = 4'd0; inst1 = 6'd0; inst2 = 4'd0;
        for (int k = 0; k < 3; k++) begin
            mret[k] = 0;
            mill[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_outs(k, "reset", IDLE_PAT);
        rst = 3'b000;
        @(negedge clk);

        // ALU latency and branches on the single-cycle-memory unit
        start(0);
        run_instr(0, 6'h01, 1'b0, 1'b0, 1'b1, halted);
        run_instr(0, 6'h08, 1'b1, 1'b0, 1'b1, halted);
        run_instr(0, 6'h08, 1'b0, 1'b1, 1'b1, halted);
        run_instr(0, 6'h09, 1'b0, 1'b1, 1'b1, halted);
        run_instr(0, 6'h0A, 1'b0, 1'b0, 1'b1, halted);
        resume(0);
        run_instr(0, 6'h0F, 1'b0, 1'b0, 1'b1, halted);
        resume(0);
        run_instr(0, 6'h07, 1'b0, 1'b0, 1'b0, halted);
        start(0);
        run_instr(0, 6'h05, 1'b0, 1'b0, 1'b0, halted);

        // Memory-operand latency and wide-opcode trap
        start(1);
        run_instr(1, 6'h04, 1'b0, 1'b0, 1'b1, halted);
        run_instr(1, 6'h26, 1'b0, 1'b0, 1'b1, halted);
        resume(1);
        run_instr(1, 6'h06, 1'b0, 1'b0, 1'b0, halted);

        // Pause during the 4th instruction's FETCH, retired counter wraps 3 -> 0
        start(2);
        run_instr(2, 6'h02, 1'b0, 1'b0, 1'b1, halted);
        run_instr(2, 6'h04, 1'b0, 1'b0, 1'b1, halted);
        run_instr(2, 6'h09, 1'b0, 1'b0, 1'b1, halted);
        run_instr(2, 6'h03, 1'b0, 1'b0, 1'b0, halted);
        chk("u2/wrap", {16'd0, get_ret(2)}, 32'd0);
        start(2);
        run_instr(2, 6'h00, 1'b0, 1'b0, 1'b1, halted);

        // Reset in the 2nd FETCH cycle with iRun still high
        #1 check_outs(2, "fetch_pre_rst", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
        @(negedge clk);
        rst[2] = 1'b1;
        mret[2] = 0;
        mill[2] = 1'b0;
        #1 check_outs(2, "rst_forced", IDLE_PAT);
        @(negedge clk);
        rst[2] = 1'b0;
        run[2] = 1'b0;
        #1 check_outs(2, "after_rst", IDLE_PAT);
        @(negedge clk);
        #1 check_outs(2, "idle_stays", IDLE_PAT);

        // Random instruction streams on u0 and u1
        for (int k = 0; k < 2; k++) begin
            in_fetch = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (!in_fetch) start(k);
                rop = 6'($urandom_range(0, 15));
                if ((k == 1) && ($urandom_range(0, 7) == 0)) rop[5:4] = 2'($urandom_range(1, 3));
                run_instr(k, rop, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, halted);
                if (halted) begin
                    resume(k);
                    in_fetch = 1'b1;
                end else begin
                    in_fetch = run[k];
                end
            end
            if (!in_fetch) start(k);
            run_instr(k, 6'h00, 1'b0, 1'b0, 1'b0, halted);
            #1 check_outs(k, "rand_end", IDLE_PAT);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
